acia_rx: RTL and testbench
==========================

# acia_rx

Serial receiver for the 6551-compatible ACIA: consumes the asynchronous line driven by the ACIA transmitter, or by an external device, and delivers parallel bytes to the CPU register interface. The line is oversampled at 16x baud using a clock-enable pulse from the baud-rate generator. Frames are 1 start bit, 8 data bits LSB-first, optional parity, and 1 checked stop bit. Data is held in a single receive holding register with full, parity, framing and overrun flags, mirroring the transmit side's frame format and parity encodings.

## Interface
- No parameters. Frame length is fixed at 8 data bits and the oversample ratio at 16.
- RESET  in  1  synchronous, active-high reset, sampled on the PHI2 rising edge.
- PHI2  in  1  the single clock; all state changes on its rising edge.
- BCLKEN  in  1  one-PHI2-cycle pulse at 16x baud; the receiver advances only on cycles where it is 1.
- RX  in  1  asynchronous serial line; idles high.
- R_PME  in  1  parity enable.
- R_PMC  in  2  parity mode: 00 odd, 01 even, 10 mark, 11 space.
- RXREAD  in  1  one-cycle pulse when the CPU reads the receive data register.
- RXDATA  out  8  received byte; reset value 0x00.
- RXFULL  out  1  holding register contains an unread byte; reset value 0.
- PERR  out  1  parity error for the byte in RXDATA; reset value 0.
- FERR  out  1  framing error, i.e. the stop bit was sampled low; reset value 0.
- OVRN  out  1  overrun: a frame completed while RXFULL was 1; reset value 0.

## Operation
- Synchronizer: RX passes through two PHI2 flops before use. Both flops reset to 1; rx_s denotes the second flop.
- Internal state, all cleared by RESET: tick counter r_clk (4 bits), bit counter r_bitcnt (3 bits), shift register (8 bits), and running parity.
- FSM states:
  - IDLE: on a BCLKEN cycle with rx_s=0, clear r_clk and go to START.
  - START: count BCLKEN ticks. At r_clk=7 (mid start bit), sample rx_s.
    - rx_s=1: false start; return to IDLE.
    - rx_s=0: clear r_clk and r_bitcnt, clear parity, go to DATA.
  - DATA: on the BCLKEN tick where r_clk=15, sample rx_s into shift-register bit 7, shifting right, and XOR the sample into parity.
    - After the 8th bit (r_bitcnt=7): go to PARITY if R_PME=1, otherwise go to STOP.
  - PARITY: at r_clk=15, sample rx_s and compare against the expected value.
    - Odd (00): expected = ~parity. Even (01): expected = parity. Mark (10): expected = 1. Space (11): expected = 0.
    - A mismatch latches an internal perr bit. Then go to STOP.
  - STOP: at r_clk=15, sample rx_s, then do the transfer below.
    - rx_s=1: go to IDLE.
    - rx_s=0: go to BRK.
  - BRK: wait in this state until a BCLKEN tick sees rx_s=1, then go to IDLE. This prevents a held-low line (break) from producing repeated frames.
- Transfer, in the same cycle as the stop-bit sample:
  - RXFULL=0, or RXREAD=1 in the same cycle: RXDATA <= shift register, RXFULL <= 1, PERR <= perr (0 if R_PME=0), FERR <= ~rx_s, OVRN <= 0.
  - RXFULL=1 and RXREAD=0: RXDATA, PERR and FERR are unchanged, OVRN <= 1, and the new byte is discarded.
- RXREAD with no transfer in the same cycle clears RXFULL, PERR, FERR and OVRN on the next edge. RXDATA holds its value.
- R_PME and R_PMC are sampled when used and must be held stable during a frame.
- RESET mid-frame: all flags and state return to reset values and the FSM goes to IDLE; the partial frame is lost. A line that is low when RESET deasserts is treated as a new start edge on the first BCLKEN.

## Timing
- One bit time is 16 BCLKEN ticks. Each sample point is nominally mid-bit: 8 ticks after the falling edge for the start bit, then every 16 ticks.
- Start-edge detection latency is the two synchronizer cycles plus wait for the next BCLKEN.
- Flags and RXDATA update on the PHI2 edge of the stop-bit-sample BCLKEN cycle and are visible the following cycle.
- Frame length from start edge to transfer: 8 + 16*8 + 16*R_PME + 16 ticks, i.e. 152 ticks without parity and 168 with.
- The receiver is ready for a new start edge on the BCLKEN tick after the transfer, so back-to-back frames with no idle gap are accepted.

## Test plan
- Frame 0xA5, no parity, good stop bit, BCLKEN every cycle -> RXFULL=1 and RXDATA=0xA5 exactly 152 ticks after the falling edge; PERR=FERR=OVRN=0; an RXREAD pulse clears RXFULL.
- 0x03 with R_PME=1, R_PMC=00, sent with the correct parity bit 1 -> PERR=0. The same byte with parity bit 0 -> PERR=1. Repeat for modes 01, 10 and 11.
- 3-tick low glitch on RX while idle -> START aborts at r_clk=7; RXFULL stays 0 and no flag changes.
- Two frames 0x11 then 0x22 with no RXREAD between them -> RXDATA=0x11, OVRN=1. Repeat with RXREAD asserted in the second frame's transfer cycle -> RXDATA=0x22, OVRN=0.
- Stop bit forced low, then line held low for 40 bit times -> exactly one transfer with FERR=1 and RXDATA=0x00; no further frames until RX goes high and a new start edge arrives.
- RESET asserted mid-DATA -> the next edge shows all outputs at reset values; a following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/acia_rx.sv
// 6551-style ACIA serial receiver: 16x oversampled, 8 data bits LSB-first,
// optional parity, one checked stop bit, single holding register with status flags.
module acia_rx (
  input  logic       PHI2,
  input  logic       RESET,
  input  logic       BCLKEN,
  input  logic       RX,
  input  logic       R_PME,
  input  logic [1:0] R_PMC,
  input  logic       RXREAD,
  output logic [7:0] RXDATA,
  output logic       RXFULL,
  output logic       PERR,
  output logic       FERR,
  output logic       OVRN
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrk} state_e;

  state_e     state_q, state_d;
  logic       rx_meta_q, rx_s_q;
  logic [3:0] r_clk_q, r_clk_d;
  logic [2:0] r_bitcnt_q, r_bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       perr_int_q, perr_int_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       rxfull_q, rxfull_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       ovrn_q, ovrn_d;
  logic       xfer;
  logic       par_exp;

  always_ff @(posedge PHI2) begin
    if (RESET) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= StIdle;
      r_clk_q    <= '0;
      r_bitcnt_q <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_int_q <= 1'b0;
      rxdata_q   <= '0;
      rxfull_q   <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovrn_q     <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      r_clk_q    <= r_clk_d;
      r_bitcnt_q <= r_bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      perr_int_q <= perr_int_d;
      rxdata_q   <= rxdata_d;
      rxfull_q   <= rxfull_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovrn_q     <= ovrn_d;
    end
  end

  always_comb begin
    unique case (R_PMC)
      2'b00:   par_exp = ~par_q;
      2'b01:   par_exp = par_q;
      2'b10:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    r_clk_d    = r_clk_q;
    r_bitcnt_d = r_bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    perr_int_d = perr_int_q;
    xfer       = 1'b0;
    if (BCLKEN) begin
      r_clk_d = r_clk_q + 4'd1;
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            r_clk_d = '0;
            state_d = StStart;
          end
        end
        StStart: begin
          // Mid start bit: a high line here means the edge was a glitch.
          if (r_clk_q == 4'd7) begin
            if (rx_s_q) begin
              state_d = StIdle;
            end else begin
              r_clk_d    = '0;
              r_bitcnt_d = '0;
              par_d      = 1'b0;
              perr_int_d = 1'b0;
              state_d    = StData;
            end
          end
        end
        StData: begin
          if (r_clk_q == 4'd15) begin
            shift_d    = {rx_s_q, shift_q[7:1]};
            par_d      = par_q ^ rx_s_q;
            r_bitcnt_d = r_bitcnt_q + 3'd1;
            if (r_bitcnt_q == 3'd7) state_d = R_PME ? StParity : StStop;
          end
        end
        StParity: begin
          if (r_clk_q == 4'd15) begin
            if (rx_s_q != par_exp) perr_int_d = 1'b1;
            state_d = StStop;
          end
        end
        StStop: begin
          if (r_clk_q == 4'd15) begin
            xfer    = 1'b1;
            state_d = rx_s_q ? StIdle : StBrk;
          end
        end
        StBrk: begin
          if (rx_s_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    rxdata_d = rxdata_q;
    rxfull_d = rxfull_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ovrn_d   = ovrn_q;
    if (xfer) begin
      // A read in the transfer cycle frees the register for the incoming byte.
      if (!rxfull_q || RXREAD) begin
        rxdata_d = shift_q;
        rxfull_d = 1'b1;
        perr_d   = R_PME & perr_int_q;
        ferr_d   = ~rx_s_q;
        ovrn_d   = 1'b0;
      end else begin
        ovrn_d = 1'b1;
      end
    end else if (RXREAD) begin
      rxfull_d = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      ovrn_d   = 1'b0;
    end
  end

  assign RXDATA = rxdata_q;
  assign RXFULL = rxfull_q;
  assign PERR   = perr_q;
  assign FERR   = ferr_q;
  assign OVRN   = ovrn_q;

endmodule

// File: tb/tb_acia_rx.sv
// Bench for acia_rx: directed frames with literal expectations plus randomized frames,
// all checked every cycle against a procedural line-sampling model of the receiver.
module tb_acia_rx;

  logic       PHI2 = 1'b0;
  logic       RESET, BCLKEN, RX, R_PME, RXREAD;
  logic [1:0] R_PMC;
  logic [7:0] RXDATA;
  logic       RXFULL, PERR, FERR, OVRN;

  int checks = 0;
  int errors = 0;

  acia_rx dut (
    .PHI2   (PHI2),
    .RESET  (RESET),
    .BCLKEN (BCLKEN),
    .RX     (RX),
    .R_PME  (R_PME),
    .R_PMC  (R_PMC),
    .RXREAD (RXREAD),
    .RXDATA (RXDATA),
    .RXFULL (RXFULL),
    .PERR   (PERR),
    .FERR   (FERR),
    .OVRN   (OVRN)
  );

  always #5 PHI2 = ~PHI2;

  int unsigned cyc = 0;
  always @(posedge PHI2) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_data = 8'h00;
  logic       m_full = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovrn = 1'b0;
  bit         hist0 = 1'b1, hist1 = 1'b1;  // RX as seen one and two edges ago
  bit         e_rst, e_bclk, e_read, e_rxs;

  task automatic edge_in();
    @(posedge PHI2);
    e_rst  = RESET;
    e_bclk = BCLKEN;
    e_read = RXREAD;
    e_rxs  = hist1;
    hist1  = RESET ? 1'b1 : hist0;
    hist0  = RESET ? 1'b1 : RX;
  endtask

  task automatic edge_out(input bit x, input logic [7:0] d, input bit p, input bit f);
    if (e_rst) begin
      m_data = 8'h00; m_full = 0; m_perr = 0; m_ferr = 0; m_ovrn = 0;
    end else if (x) begin
      if (!m_full || e_read) begin
        m_data = d; m_full = 1; m_perr = p; m_ferr = f; m_ovrn = 0;
      end else begin
        m_ovrn = 1;
      end
    end else if (e_read) begin
      m_full = 0; m_perr = 0; m_ferr = 0; m_ovrn = 0;
    end
  endtask

  // Returns at the next BCLKEN edge with its flag update still pending, or r=1 on reset.
  task automatic next_tick(output bit r);
    edge_in();
    while (!e_rst && !e_bclk) begin
      edge_out(0, 8'h00, 0, 0);
      edge_in();
    end
    r = e_rst;
    if (r) edge_out(0, 8'h00, 0, 0);
  endtask

  task automatic ticks(input int n, output bit r);
    for (int i = 0; i < n; i++) begin
      next_tick(r);
      if (r) return;
      if (i != n - 1) edge_out(0, 8'h00, 0, 0);
    end
  endtask

  task automatic frame();
    bit r, rxs, par, pe, pexp;
    logic [7:0] sh;
    next_tick(r);
    if (r) return;
    rxs = e_rxs;
    edge_out(0, 8'h00, 0, 0);
    if (rxs) return;
    ticks(8, r);
    if (r) return;
    rxs = e_rxs;
    edge_out(0, 8'h00, 0, 0);
    if (rxs) return;
    par = 0; pe = 0; sh = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ticks(16, r);
      if (r) return;
      sh[i] = e_rxs;
      par   = par ^ e_rxs;
      edge_out(0, 8'h00, 0, 0);
    end
    if (R_PME) begin
      ticks(16, r);
      if (r) return;
      case (R_PMC)
        2'b00:   pexp = ~par;
        2'b01:   pexp = par;
        2'b10:   pexp = 1'b1;
        default: pexp = 1'b0;
      endcase
      pe = (e_rxs != pexp);
      edge_out(0, 8'h00, 0, 0);
    end
    ticks(16, r);
    if (r) return;
    rxs = e_rxs;
    edge_out(1, sh, pe, !rxs);
    while (!rxs) begin
      next_tick(r);
      if (r) return;
      rxs = e_rxs;
      edge_out(0, 8'h00, 0, 0);
    end
  endtask

  initial begin
    forever frame();
  end

  always @(negedge PHI2) begin
    chk("rxdata", RXDATA, m_data);
    chk("rxfull", {7'd0, RXFULL}, {7'd0, m_full});
    chk("perr",   {7'd0, PERR},   {7'd0, m_perr});
    chk("ferr",   {7'd0, FERR},   {7'd0, m_ferr});
    chk("ovrn",   {7'd0, OVRN},   {7'd0, m_ovrn});
  end

  bit          full_prev = 1'b0;
  int unsigned rise_cyc = 0;
  always @(negedge PHI2) begin
    if (RXFULL && !full_prev) rise_cyc = cyc;
    full_prev = RXFULL;
  end

  // ---------------- stimulus ----------------
  bit          rd_next = 1'b0;
  bit          rd_rand = 1'b0;
  int unsigned bclk_div = 1;
  int unsigned fall_cyc = 0;

  task automatic cycle(output bit was_tick);
    @(negedge PHI2);
    was_tick = BCLKEN;
    RXREAD   = rd_next || (rd_rand && $urandom_range(0, 47) == 0);
    rd_next  = 1'b0;
    BCLKEN   = (bclk_div <= 1) ? 1'b1 : ($urandom_range(0, bclk_div - 1) == 0);
  endtask

  task automatic hold_ticks(input int n);
    int c = 0;
    bit t;
    while (c < n) begin
      cycle(t);
      if (t) c++;
    end
  endtask

  task automatic idle_ticks(input int n);
    RX = 1'b1;
    hold_ticks(n);
  endtask

  task automatic do_read();
    bit t;
    rd_next = 1'b1;
    cycle(t);
    cycle(t);
  endtask

  // read_at (cycles after the start edge is driven, BCLKEN=1 only) pulses RXREAD; 0 = none.
  task automatic send_frame(input logic [7:0] d, input bit pme, input bit pbit, input bit stopb,
                            input int read_at);
    logic [10:0] lv;
    int nb, tk, c;
    bit t;
    lv = '1;
    lv[0] = 1'b0;
    lv[8:1] = d;
    if (pme) begin
      lv[9] = pbit; lv[10] = stopb; nb = 11;
    end else begin
      lv[9] = stopb; nb = 10;
    end
    fall_cyc = cyc;
    tk = 0;
    for (int b = 0; b < nb; b++) begin
      RX = lv[b];
      c = 0;
      while (c < 16) begin
        if (read_at != 0 && tk == read_at - 1) rd_next = 1'b1;
        cycle(t);
        tk++;
        if (t) c++;
      end
    end
  endtask

  initial begin
    bit t;
    bit good;
    int n;
    RESET = 1'b1; BCLKEN = 1'b0; RX = 1'b1; R_PME = 1'b0; R_PMC = 2'b00; RXREAD = 1'b0;
    repeat (3) cycle(t);
    RESET = 1'b0;
    chk("reset_rxdata", RXDATA, 8'h00);
    chk("reset_rxfull", {7'd0, RXFULL}, 8'h00);
    chk("reset_flags", {5'd0, PERR, FERR, OVRN}, 8'h00);

    // Basic frame and latency: detection 2 cycles after the drive, transfer 152 ticks later.
    idle_ticks(20);
    send_frame(8'hA5, 0, 0, 1, 0);
    chk("a5_rxdata", RXDATA, 8'hA5);
    chk("a5_model_rxdata", m_data, 8'hA5);
    chk("a5_rxfull", {7'd0, RXFULL}, 8'h01);
    chk("a5_flags", {5'd0, PERR, FERR, OVRN}, 8'h00);
    chk_int("a5_latency", int'(rise_cyc - fall_cyc), 155);
    do_read();
    chk("a5_read_clears", {7'd0, RXFULL}, 8'h00);

    // 0x03 has even population, so XOR parity is 0: correct bit is 1,0,1,0 for modes 00..11.
    for (int m = 0; m < 4; m++) begin
      R_PME = 1'b1;
      R_PMC = 2'(m);
      good  = (m == 0 || m == 2);
      idle_ticks(4);
      send_frame(8'h03, 1, good, 1, 0);
      chk("par_good_rxdata", RXDATA, 8'h03);
      chk("par_good_perr", {7'd0, PERR}, 8'h00);
      do_read();
      idle_ticks(4);
      send_frame(8'h03, 1, !good, 1, 0);
      chk("par_bad_perr", {7'd0, PERR}, 8'h01);
      chk("par_bad_model_perr", {7'd0, m_perr}, 8'h01);
      do_read();
    end
    R_PME = 1'b0;

    // Short glitch while idle.
    idle_ticks(10);
    RX = 1'b0;
    repeat (3) cycle(t);
    idle_ticks(40);
    chk("glitch_rxfull", {7'd0, RXFULL}, 8'h00);
    chk("glitch_flags", {5'd0, PERR, FERR, OVRN}, 8'h00);

    // Overrun, then the same pair with a read in the second transfer cycle.
    send_frame(8'h11, 0, 0, 1, 0);
    send_frame(8'h22, 0, 0, 1, 0);
    chk("ovrn_rxdata", RXDATA, 8'h11);
    chk("ovrn_set", {7'd0, OVRN}, 8'h01);
    do_read();
    chk("ovrn_read_clears", {7'd0, OVRN}, 8'h00);
    idle_ticks(4);
    send_frame(8'h11, 0, 0, 1, 0);
    send_frame(8'h22, 0, 0, 1, 154);
    chk("rdxfer_rxdata", RXDATA, 8'h22);
    chk("rdxfer_ovrn", {7'd0, OVRN}, 8'h00);
    chk("rdxfer_rxfull", {7'd0, RXFULL}, 8'h01);
    do_read();

    // Break: low stop bit then line held low for 40 bit times.
    idle_ticks(4);
    send_frame(8'h00, 0, 0, 0, 0);
    hold_ticks(640);
    chk("brk_rxdata", RXDATA, 8'h00);
    chk("brk_ferr", {7'd0, FERR}, 8'h01);
    chk("brk_ovrn", {7'd0, OVRN}, 8'h00);
    idle_ticks(40);
    chk("brk_release_ovrn", {7'd0, OVRN}, 8'h00);
    do_read();
    idle_ticks(4);
    send_frame(8'h3C, 0, 0, 1, 0);
    chk("post_brk_rxdata", RXDATA, 8'h3C);
    chk("post_brk_ferr", {7'd0, FERR}, 8'h00);

    // Reset in the middle of the data bits, register still full.
    RX = 1'b0;
    hold_ticks(16);
    RX = 1'b1;
    hold_ticks(40);
    RESET = 1'b1;
    cycle(t);
    RESET = 1'b0;
    chk("midreset_rxdata", RXDATA, 8'h00);
    chk("midreset_rxfull", {7'd0, RXFULL}, 8'h00);
    chk("midreset_flags", {5'd0, PERR, FERR, OVRN}, 8'h00);
    idle_ticks(20);
    send_frame(8'h5A, 0, 0, 1, 0);
    chk("post_reset_rxdata", RXDATA, 8'h5A);
    chk("post_reset_flags", {5'd0, PERR, FERR, OVRN}, 8'h00);
    do_read();

    // Randomized frames, sparse BCLKEN and random reads.
    rd_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit stopb;
      bclk_div = $urandom_range(1, 3);
      R_PME    = 1'($urandom_range(0, 1));
      R_PMC    = 2'($urandom_range(0, 3));
      stopb    = ($urandom_range(0, 7) != 0);
      send_frame(8'($urandom), R_PME, 1'($urandom_range(0, 1)), stopb, 0);
      n = stopb ? int'($urandom_range(0, 20)) : int'($urandom_range(3, 20));
      idle_ticks(n);
    end
    rd_rand  = 1'b0;
    bclk_div = 1;
    idle_ticks(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
